// File: rtl/game_ctrl_fsm.sv
// Flappy Bird game-state controller on the 2 ms tick: IDLE/PLAY/DYING/OVER sequencing,
// collision detection, flap pulses and best-score tracking. Optional macro: GAME_CTRL_GODMODE_EN.
module game_ctrl_fsm #(
  parameter int unsigned SLOT_WIDTH   = 60,
  parameter int unsigned SLOT_HEIGHT  = 100,
  parameter int unsigned BIRD_HPOS    = 320,
  parameter int unsigned BIRD_XWIDTH  = 34,
  parameter int unsigned BIRD_YHEIGHT = 24,
  parameter int unsigned GROUND_Y     = 436,
  parameter int unsigned DYING_TICKS  = 500,
  parameter int unsigned OVER_LOCK    = 250
) (
  input  logic       clk_2ms,
  input  logic       rst_n,
  input  logic       btn_flap,
  input  logic [8:0] bird_Y,
  input  logic [9:0] pip_X,
  input  logic [8:0] pip_Y,
  input  logic [7:0] score,
  output logic [1:0] state,
  output logic       flap,
  output logic [7:0] best_score,
  output logic       new_best
);

  localparam int unsigned CNT_MAX = (DYING_TICKS > OVER_LOCK) ? DYING_TICKS : OVER_LOCK;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef GAME_CTRL_GODMODE_EN
  localparam bit PIPE_KILL_EN = 1'b0;
`else
  localparam bit PIPE_KILL_EN = 1'b1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flap_q, flap_d;
  logic [7:0]         best_q, best_d;
  logic               new_best_q, new_best_d;
  logic               sync1_q, sync2_q, prev_q;

  logic               flap_edge_c;
  logic [9:0]         bird_ext_c;
  logic [9:0]         pip_y_ext_c;
  logic [9:0]         bird_top_sum_c;
  logic [9:0]         bird_bot_sum_c;
  logic               hx_c;
  logic               pipe_hit_c;
  logic               ground_hit_c;

  // Button synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_flap;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign flap_edge_c = sync2_q & ~prev_q;

  // Collision detection; pipe_X is only compared against constants so it never underflows
  always_comb begin
    bird_ext_c     = {1'b0, bird_Y};
    pip_y_ext_c    = {1'b0, pip_Y};
    bird_top_sum_c = bird_ext_c + 10'(SLOT_HEIGHT);
    bird_bot_sum_c = bird_ext_c + 10'(BIRD_YHEIGHT);
    hx_c           = (pip_X > 10'(BIRD_HPOS - BIRD_XWIDTH)) &&
                     (pip_X < 10'(BIRD_HPOS + SLOT_WIDTH));
    pipe_hit_c     = PIPE_KILL_EN && hx_c &&
                     ((bird_top_sum_c < pip_y_ext_c) || (bird_bot_sum_c > pip_y_ext_c));
    ground_hit_c   = (bird_bot_sum_c >= 10'(GROUND_Y));
  end

  // State register and registered outputs
  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flap_q     <= 1'b0;
      best_q     <= 8'd0;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flap_q     <= flap_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flap_d     = 1'b0;
    best_d     = best_q;
    new_best_d = new_best_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (flap_edge_c) begin
          state_d = ST_PLAY;
          flap_d  = 1'b1;
        end
      end

      ST_PLAY: begin
        cnt_d = '0;
        if (ground_hit_c || pipe_hit_c) begin
          state_d = ground_hit_c ? ST_OVER : ST_DYING;
          if (score > best_q) begin
            best_d     = score;
            new_best_d = 1'b1;
          end
        end else if (flap_edge_c) begin
          flap_d = 1'b1;
        end
      end

      ST_DYING: begin
        if (ground_hit_c || (cnt_q == CNT_W'(DYING_TICKS - 1))) begin
          state_d = ST_OVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_OVER: begin
        // Presses during the lockout are dropped, not queued
        if (flap_edge_c && (cnt_q == CNT_W'(OVER_LOCK))) begin
          state_d    = ST_IDLE;
          new_best_d = 1'b0;
          cnt_d      = '0;
        end else if (cnt_q < CNT_W'(OVER_LOCK)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state      = state_q;
  assign flap       = flap_q;
  assign best_score = best_q;
  assign new_best   = new_best_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed self-checking bench for game_ctrl_fsm; define GAME_CTRL_GODMODE_EN for the godmode build.
module tb_game_ctrl_fsm;

  logic       clk_2ms;
  logic       rst_n;
  logic       btn_flap;
  logic [8:0] bird_Y;
  logic [9:0] pip_X;
  logic [8:0] pip_Y;
  logic [7:0] score;
  logic [1:0] state;
  logic       flap;
  logic [7:0] best_score;
  logic       new_best;

  int checks = 0;
  int errors = 0;

  game_ctrl_fsm dut (
    .clk_2ms    (clk_2ms),
    .rst_n      (rst_n),
    .btn_flap   (btn_flap),
    .bird_Y     (bird_Y),
    .pip_X      (pip_X),
    .pip_Y      (pip_Y),
    .score      (score),
    .state      (state),
    .flap       (flap),
    .best_score (best_score),
    .new_best   (new_best)
  );

  initial clk_2ms = 1'b0;
  always #5 clk_2ms = ~clk_2ms;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2ms);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press the button right after an edge; the press is acted on at the third edge after it
  task automatic press_and_act();
    btn_flap = 1'b1;
    tick_n(3);
  endtask

  int flap_seen;

  initial begin
    rst_n    = 1'b0;
    btn_flap = 1'b0;
    bird_Y   = 9'd100;
    pip_X    = 10'd0;
    pip_Y    = 9'd300;
    score    = 8'd0;
    #12;
    check("rst_state", state, 0);
    check("rst_flap", flap, 0);
    check("rst_best", best_score, 0);
    check("rst_new_best", new_best, 0);
    #10 rst_n = 1'b1;
    tick();

    // IDLE ignores a ground collision
    bird_Y = 9'd420;
    tick_n(2);
    check("idle_ignore_ground", state, 0);
    bird_Y = 9'd100;
    tick();

    // Start: press, two sync edges, then PLAY with one flap pulse
    btn_flap = 1'b1;
    tick();
    check("start_k_state", state, 0);
    tick();
    check("start_k1_flap", flap, 0);
    tick();
    check("start_k2_state", state, 1);
    check("start_k2_flap", flap, 1);
    tick();
    check("start_k3_flap", flap, 0);
    flap_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      flap_seen |= int'(flap);
    end
    check("hold_no_flap", flap_seen, 0);
    btn_flap = 1'b0;
    tick_n(3);

    // In-flight flap while playing
    press_and_act();
    check("play_flap", flap, 1);
    tick();
    check("play_flap_done", flap, 0);
    btn_flap = 1'b0;

    // Horizontal overlap boundaries and exact gap-edge contact
    pip_Y  = 9'd300;
    bird_Y = 9'd150;
    pip_X  = 10'd286;
    tick();
    check("hx_left_bound", state, 1);
    pip_X = 10'd380;
    tick();
    check("hx_right_bound", state, 1);
    pip_X  = 10'd300;
    bird_Y = 9'd200;
    tick();
    check("gap_exact_edge", state, 1);
    bird_Y = 9'd411;
    pip_X  = 10'd0;
    tick();
    check("ground_just_above", state, 1);

    // Pipe hit with score 5 on a fresh best
    score  = 8'd5;
    bird_Y = 9'd150;
    pip_X  = 10'd287;
    tick();
`ifdef GAME_CTRL_GODMODE_EN
    check("god_pipe_no_hit", state, 1);
    pip_X  = 10'd0;
    bird_Y = 9'd420;
    tick();
    check("god_ground_over", state, 3);
    check("god_best", best_score, 5);
    check("god_new_best", new_best, 1);
`else
    check("pipe_hit_dying", state, 2);
    check("pipe_hit_best", best_score, 5);
    check("pipe_hit_new_best", new_best, 1);
    check("dying_flap", flap, 0);
    pip_X  = 10'd0;
    bird_Y = 9'd100;
    flap_seen = 0;
    for (int i = 1; i <= 499; i++) begin
      if (i == 10) btn_flap = 1'b1;
      if (i == 20) btn_flap = 1'b0;
      tick();
      flap_seen |= int'(flap);
    end
    check("dying_499_state", state, 2);
    check("dying_no_flap", flap_seen, 0);
    tick();
    check("dying_500_over", state, 3);
`endif
    bird_Y = 9'd100;

    // OVER lockout: now just after entry edge o0
    tick_n(97);
    press_and_act();
    check("over_early_ignored", state, 3);
    btn_flap = 1'b0;
    tick_n(147);
    press_and_act();
    check("over_lock_bound", state, 3);
    btn_flap = 1'b0;
    tick_n(2);
    press_and_act();
    check("over_to_idle", state, 0);
    check("over_exit_new_best", new_best, 0);
    check("over_exit_best", best_score, 5);
    check("over_exit_flap", flap, 0);
    btn_flap = 1'b0;
    tick_n(3);

    // Second run: equal score, simultaneous ground and pipe hit
    press_and_act();
    check("run2_play", state, 1);
    btn_flap = 1'b0;
    pip_X  = 10'd300;
    pip_Y  = 9'd300;
    bird_Y = 9'd412;
    tick();
    check("ground_priority", state, 3);
    check("equal_no_new_best", new_best, 0);
    check("equal_best_kept", best_score, 5);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", state, 0);
    check("midrst_best", best_score, 0);
    #10 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Top-level game-state controller for the Flappy Bird datapath; runs on the 2 ms game tick.
- Produces the 2-bit `state` consumed by the pipe generator, so it sits directly upstream of it.
- Consumes the generator's pipe position and score, plus bird height and the flap button.
- Detects pipe and ground collisions, sequences IDLE/PLAY/DYING/OVER, issues flap pulses to bird physics, and keeps the best score.

Parameters:
- SLOT_WIDTH, 60, pipe width in pixels.
- SLOT_HEIGHT, 100, vertical gap height in pixels.
- BIRD_HPOS, 320, bird right-edge x (exclusive).
- BIRD_XWIDTH, 34, bird width.
- BIRD_YHEIGHT, 24, bird height.
- GROUND_Y, 436, first y row of land (480 - 44).
- DYING_TICKS, 500, max ticks in DYING (1 s).
- OVER_LOCK, 250, ticks in OVER before a flap is accepted (0.5 s).

Ports:
- clk_2ms  in  1  game tick clock, 2 ms period.
- rst_n  in  1  asynchronous active-low reset.
- btn_flap  in  1  raw flap button, asynchronous, active-high.
- bird_Y  in  9  bird top-edge y, 0 = screen top.
- pip_X  in  10  pipe right-edge x (exclusive); pipe spans [pip_X-SLOT_WIDTH, pip_X).
- pip_Y  in  9  gap bottom edge y; gap spans [pip_Y-SLOT_HEIGHT, pip_Y).
- score  in  8  current score.
- state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER.
- flap  out  1  one-tick flap pulse to bird physics.
- best_score  out  8  highest score since reset.
- new_best  out  1  high while in OVER when the last run beat the previous best.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and internal state:
  - state=0, flap=0, best_score=0, new_best=0.
  - Synchronizer flops=0, tick counter=0.
- Button path:
  - 2-flop synchronizer, then prev flop.
  - flap_edge = sync2 & ~prev.
  - A press first captured at edge k is acted on at edge k+2; one edge per press.
  - Holding the button produces nothing further.
- Horizontal overlap hx = (pip_X > BIRD_HPOS-BIRD_XWIDTH) && (pip_X < BIRD_HPOS+SLOT_WIDTH).
  - Evaluate with no subtraction on pip_X, so pip_X < SLOT_WIDTH never underflows.
- Pipe hit = hx && ((bird_Y+SLOT_HEIGHT < pip_Y) || (bird_Y+BIRD_YHEIGHT > pip_Y)).
  - All sums are 10-bit zero-extended.
  - Exact edge contact is not a hit.
- Ground hit = bird_Y+BIRD_YHEIGHT >= GROUND_Y. bird_Y=0 (ceiling) is not a hit.
- IDLE:
  - On flap_edge: state->PLAY, flap=1 for that tick.
  - Collisions are ignored.
- PLAY:
  - Ground hit -> OVER. Ground has priority if a pipe hit occurs on the same tick.
  - Else pipe hit -> DYING.
  - Else flap_edge -> flap=1, state stays PLAY.
  - Transition occurs on the same edge the combinational hit is seen (1-tick latency).
  - Tick counter is cleared on exit.
- Best-score update on any exit from PLAY:
  - If score > best_score: best_score<=score, new_best<=1.
  - Equal score does not set new_best.
- DYING:
  - Counter increments each tick; flap is never asserted and the button is ignored.
  - Ground hit or counter==DYING_TICKS-1 -> OVER, counter cleared.
- OVER:
  - Counter increments and saturates at OVER_LOCK.
  - flap_edge while counter<OVER_LOCK is discarded, not remembered.
  - flap_edge once counter==OVER_LOCK -> IDLE, new_best<=0, counter cleared.
  - flap is not asserted on this transition.
- flap is a registered output. It is 0 on every tick not listed above and is never high 2 consecutive ticks.
- Reset mid-run returns to IDLE immediately; best_score is lost.
- state encodings 2 and 3 both freeze the pipe generator; 0 resets it.

Optional Feature:
- Macro: GAME_CTRL_GODMODE_EN.
- Defined: pipe hit is forced to 0. Only ground hit ends PLAY (-> OVER); DYING is unreachable but still encoded.
- Undefined: behaviour as above.

Test Plan:
- Reset then btn_flap high at edge k -> state=1 and flap=1 at edge k+2, flap=0 at k+3; holding button gives no further flap.
- PLAY, pip_X=300, pip_Y=300, bird_Y=150 (150+100<300) -> state=2 next edge. Same with bird_Y=200 -> stays 1, no hit at exact edge.
- PLAY, bird_Y=412 (412+24=436) with simultaneous pipe hit -> state=3 directly, not 2.
- PLAY score=5, best=0, pipe hit -> best_score=5, new_best=1. Hold bird_Y=100 in DYING -> OVER after exactly 500 ticks.
- OVER: flap at tick 100 ignored. Flap after tick 250 -> state=0, new_best=0, best_score=5. Next run score=5 ends -> new_best stays 0.
- With GAME_CTRL_GODMODE_EN: pipe-overlap stimulus -> state stays 1. bird_Y=420 -> state=3.
